// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper: arm, count cycles, snapshot registers on halt/timeout, stream them out.
// Define DUMP_PC_EN to append the program counter as an extra final word.
module cpu_state_dumper #(
    parameter int DATA_W  = 16,
    parameter int N_REGS  = 3,
    parameter int PC_W    = 10,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 20000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     hlt,
    input  logic [N_REGS*DATA_W-1:0] regs,
    input  logic [PC_W-1:0]          pc,
    output logic [DATA_W-1:0]        dump_data,
    output logic [4:0]               dump_idx,
    output logic                     dump_valid,
    input  logic                     dump_ready,
    output logic                     dump_last,
    output logic                     busy,
    output logic                     done,
    output logic                     cause,
    output logic [CNT_W-1:0]         cycle_count
);
`ifdef DUMP_PC_EN
    localparam int NW = N_REGS + 1;
`else
    localparam int NW = N_REGS;
    logic unused_pc;
    assign unused_pc = ^pc;
`endif
    typedef enum logic [1:0] {IDLE, RUN, STREAM, DONE} state_t;
    state_t state, state_nxt;
    logic [DATA_W-1:0] snap [NW];
    logic trig;
    assign trig = hlt || cycle_count == CNT_W'(TIMEOUT - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = arm ? RUN : state;
            RUN:        state_nxt = trig ? STREAM : RUN;
            STREAM:     state_nxt = (dump_ready && dump_last) ? DONE : STREAM;
            default:    state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cycle_count <= '0;
            cause <= 1'b0;
            dump_idx <= '0;
            for (int i = 0; i < NW; i++) snap[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (arm) begin
                    cycle_count <= '0;
                    cause <= 1'b0;
                end
                RUN: begin
                    cycle_count <= cycle_count + CNT_W'(1);
                    if (trig) begin
                        cause <= !hlt;
                        dump_idx <= '0;
                        for (int i = 0; i < N_REGS; i++) snap[i] <= regs[i*DATA_W +: DATA_W];
`ifdef DUMP_PC_EN
                        snap[N_REGS] <= DATA_W'(pc);
`endif
                    end
                end
                STREAM: if (dump_ready && !dump_last) dump_idx <= dump_idx + 5'd1;
                default: ;
            endcase
        end
    // Moore outputs: everything decodes from registered state and index.
    always_comb begin
        dump_valid = state == STREAM;
        dump_last = dump_valid && dump_idx == 5'(NW - 1);
        busy = state == RUN || state == STREAM;
        done = state == DONE;
        dump_data = '0;
        for (int i = 0; i < NW; i++) if (dump_valid && dump_idx == 5'(i)) dump_data = snap[i];
    end
endmodule
